// File: rtl/cond_gen_pkg.sv
// ----------------------------------------------------------------------------
// cond_gen_pkg
// Shared types and constants for the conditional-generate lane array.
//   lane_mode_e : elaboration-time selection of the per-lane datapath
//   COUNT_W     : width of the accepted-beat counter
//   COUNT_MAX   : saturation value of the accepted-beat counter
//   sat_inc()   : saturating increment used by the beat counter
// ----------------------------------------------------------------------------
package cond_gen_pkg;

    typedef enum logic [1:0] {
        LANE_REG   = 2'd0,
        LANE_ACC   = 2'd1,
        LANE_DELAY = 2'd2
    } lane_mode_e;

    localparam int                 COUNT_W   = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

    // Increment that sticks at COUNT_MAX instead of wrapping to zero.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        logic [COUNT_W-1:0] result;
        if (value == COUNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage : cond_gen_pkg

// File: rtl/cond_gen_lane.sv
// ----------------------------------------------------------------------------
// cond_gen_lane
// One data lane of the array. The datapath is fixed at elaboration by MODE:
//   LANE_REG   : single register stage, loads on in_valid, holds otherwise
//   LANE_ACC   : WIDTH-bit wrapping accumulator, adds in_data on in_valid
//   LANE_DELAY : DEPTH-stage shift register that advances every cycle
// Each branch owns its own block-local state. The valid pipeline lives in
// the parent because it is identical for every lane.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clear    in   synchronous clear of lane state
//   in_valid in   beat qualifier (shared by all lanes)
//   in_data  in   WIDTH-bit lane input
//   out_data out  WIDTH-bit registered lane result
// ----------------------------------------------------------------------------
module cond_gen_lane
    import cond_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    generate
        if (MODE == int'(LANE_REG)) begin : g_reg
            logic [WIDTH-1:0] r_data;

            // Capture register: a beat wins over clear, clear alone zeroes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= ZERO;
                end else if (in_valid) begin
                    r_data <= in_data;
                end else if (clear) begin
                    r_data <= ZERO;
                end
            end

            assign out_data = r_data;

        end else if (MODE == int'(LANE_ACC)) begin : g_acc
            logic [WIDTH-1:0] r_sum;

            // Wrapping accumulator; with clear the old sum is dropped but
            // the current beat still counts, so the sum restarts at in_data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= ZERO;
                end else if (in_valid) begin
                    r_sum <= (clear ? ZERO : r_sum) + in_data;
                end else if (clear) begin
                    r_sum <= ZERO;
                end
            end

            assign out_data = r_sum;

        end else if (MODE == int'(LANE_DELAY)) begin : g_delay
            if (DEPTH < 2 || DEPTH > 16) begin : g_depth_bad
                $error("cond_gen_lane: DEPTH must be in 2..16");
            end

            logic [WIDTH-1:0] r_stage [DEPTH];
            logic [WIDTH-1:0] w_head;

            // Bubbles enter as zero so idle slots never carry stale data.
            assign w_head = in_valid ? in_data : ZERO;

            // Free-running shift; clear flushes every stage behind the head.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= ZERO;
                    end
                end else begin
                    r_stage[0] <= w_head;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= clear ? ZERO : r_stage[i-1];
                    end
                end
            end

            assign out_data = r_stage[DEPTH-1];

        end else begin : g_bad_mode
            $error("cond_gen_lane: MODE must be 0 (REG), 1 (ACC) or 2 (DELAY)");
            assign out_data = ZERO;
        end
    endgenerate

endmodule : cond_gen_lane

// File: rtl/cond_gen_lane_array.sv
// ----------------------------------------------------------------------------
// cond_gen_lane_array
// CHANNELS identical lanes whose datapath is selected by MODE at elaboration.
// The top owns the valid pipeline (shared by all lanes) and the saturating
// count of accepted beats.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous clear of lane state, valids and counter
//   in_valid     in   input beat qualifier, common to all lanes
//   in_data      in   CHANNELS*WIDTH, lane c at [c*WIDTH +: WIDTH]
//   out_valid    out  registered output beat qualifier
//   out_data     out  CHANNELS*WIDTH, same packing as in_data
//   sample_count out  16-bit accepted-beat count, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module cond_gen_lane_array
    import cond_gen_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int DEPTH    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [COUNT_W-1:0]        sample_count
);

    // REG and ACC answer one cycle after the beat; DELAY after DEPTH cycles.
    localparam int VLAT = (MODE == int'(LANE_DELAY)) ? DEPTH : 1;

    logic [VLAT-1:0]           r_vpipe;
    logic [COUNT_W-1:0]        r_count;
    logic [CHANNELS*WIDTH-1:0] w_lane_out;

    // Shared valid pipeline; the head always takes the current beat so a
    // beat arriving together with clear still emerges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpipe <= {VLAT{1'b0}};
        end else begin
            r_vpipe[0] <= in_valid;
            for (int i = 1; i < VLAT; i++) begin
                r_vpipe[i] <= clear ? 1'b0 : r_vpipe[i-1];
            end
        end
    end

    // Accepted-beat counter; clear restarts it, counting a coincident beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'd0;
        end else if (clear) begin
            r_count <= in_valid ? 16'd1 : 16'd0;
        end else if (in_valid) begin
            r_count <= sat_inc(r_count);
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
            cond_gen_lane #(
                .WIDTH (WIDTH),
                .MODE  (MODE),
                .DEPTH (DEPTH)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (clear),
                .in_valid (in_valid),
                .in_data  (in_data[c*WIDTH +: WIDTH]),
                .out_data (w_lane_out[c*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign out_valid    = r_vpipe[VLAT-1];
    assign out_data     = w_lane_out;
    assign sample_count = r_count;

endmodule : cond_gen_lane_array

// File: doc/cond_gen_lane_array.md
Name: cond_gen_lane_array

Overview:
- Parametrised array of CHANNELS identical data lanes.
- Each lane's datapath is chosen at elaboration by a MODE generate-if / else-if / else chain: register stage, wrapping accumulator, or DEPTH-stage delay line.
- Each branch declares its own block-local state, so the block doubles as an indexer/elaboration stress case for scoped generate declarations inside generate-for loops.
- Sits in the verification-fixture library as a synthesizable, simulatable successor to single-level conditional-generate fixtures.

Parameters:
- WIDTH, 8, data bits per channel (1..32).
- CHANNELS, 4, number of lanes (1..16).
- MODE, 0, lane datapath: 0 = REG, 1 = ACC, 2 = DELAY; any other value is an elaboration error via $error.
- DEPTH, 3, delay-line stages in DELAY mode (2..16); ignored otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of lane state and sample counter.
- in_valid  in  1  input beat qualifier, common to all lanes.
- in_data  in  CHANNELS*WIDTH  lane c occupies bits [c*WIDTH +: WIDTH].
- out_valid  out  1  output beat qualifier.
- out_data  out  CHANNELS*WIDTH  per-lane result, same packing as in_data.
- sample_count  out  16  number of accepted in_valid beats, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, sample_count = 0, all lane state = 0. State is held while rst_n is low.
- Reset release mid-stream: in-flight beats are discarded and no spurious out_valid appears.
- REG mode:
  - Latency 1: out_valid(t+1) = in_valid(t).
  - out_data loads in_data only when in_valid = 1; otherwise out_data holds its value.
- ACC mode:
  - Per lane, sum is WIDTH bits and wraps modulo 2^WIDTH, with no carry out.
  - On in_valid: sum <= sum + lane_in.
  - out_data = registered sum. out_valid is asserted the cycle after each accepted beat, so latency is 1.
- DELAY mode:
  - DEPTH-stage shift register of {valid, data} per lane. The valid bit is shared across lanes.
  - out_valid and out_data appear exactly DEPTH cycles after input.
  - The pipeline shifts every cycle whether or not in_valid is set, so bubbles are preserved.
- clear (all modes, synchronous):
  - Zeroes lane state, out_data and sample_count.
  - Drops all in-flight valids, including the DELAY pipeline, and forces out_valid = 0 in the next cycle.
- clear and in_valid in the same cycle:
  - clear takes priority for old state; the current beat is still accepted.
  - ACC: sum <= lane_in.
  - REG: out_data <= lane_in with out_valid = 1.
  - DELAY: pipeline stage 0 loads the beat and all later stages are zeroed.
  - sample_count <= 1.
- sample_count:
  - Increments on in_valid.
  - Saturates at 16'hFFFF: no wrap; in_valid at the maximum leaves it unchanged.
- No backpressure; input is always accepted.
- All outputs are registered; no combinational path runs from inputs to outputs.

Decomposition:
- Package cond_gen_pkg:
  - Typedef enum lane_mode_e {LANE_REG = 0, LANE_ACC = 1, LANE_DELAY = 2}.
  - localparam COUNT_W = 16 and COUNT_MAX.
- Sub-module cond_gen_lane:
  - Parameterised by WIDTH, MODE, DEPTH.
  - Contains the generate-if / else-if / else chain, with each branch declaring its local state registers.
  - Excludes the valid/clear pipeline, which is shared.
- Top level:
  - Instantiates CHANNELS lanes in a named generate-for.
  - Owns the shared valid pipeline and the sample counter.

Test Plan:
- REG, WIDTH=8, CHANNELS=4: reset, then one beat in_data=32'h44332211 -> next cycle out_valid=1, out_data=32'h44332211; following cycle out_valid=0 with out_data held.
- ACC, WIDTH=8: lane0 fed 8'hF0, 8'h20, 8'h05 on consecutive beats -> out_data lane0 = 8'hF0, 8'h10 (wrap), 8'h15; then clear with in_valid and 8'h07 -> lane0 = 8'h07, sample_count = 1.
- DELAY, DEPTH=3: in_valid pattern 1,0,1 with data A, x, C -> out_valid 1,0,1 at cycles t+3..t+5 carrying A, then C, with the bubble preserved.
- DELAY: assert clear while 2 beats are in flight -> no out_valid for the next 3 cycles; sample_count = 0.
- Saturation: preload 16'hFFFE via 65534 beats, then 3 more beats -> sample_count = 16'hFFFF and stays there.
- Async reset: drop rst_n mid-cycle during an ACC stream -> outputs go to 0 immediately without waiting for clk; after release, the first beat 8'h09 gives lane sum 8'h09.
